// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Game-logic core for Pong. On each rising edge of the slow game clock it
//   moves both paddles from the debounced buttons, then advances the ball.
//   The ball bounces off the top and bottom walls and off paddle faces. When a
//   player misses, the opponent scores in BCD. A win freezes the game until
//   reset. Every y value is in the display-shifted domain
//   (stored y = screen y + disp_shift).
//
// Ports
//   clk100Hz      in   game tick; one update per rising edge
//   reset         in   asynchronous, active-high
//   pause         in   1 = hold every register
//   btn[3:0]      in   active-high: [3] p1 up, [2] p1 down, [1] p2 up, [0] p2 down
//   score_*_*     out  BCD digits of each player's score
//   paddle_*_y    out  paddle top y (shifted)
//   ball_x/_y     out  ball top-left corner
//   winner        out  00 none, 01 player 1, 10 player 2
//   dbg_state     out  FSM state: 0 SERVE, 1 PLAY, 2 GAME_OVER
module pong_game_engine #(
    parameter int upper_lim_y       = 470,
    parameter int lower_lim_y       = 5,
    parameter int upper_lim_x       = 640,
    parameter int lower_lim_x       = 10,
    parameter int BALL_SIZE         = 5,
    parameter int initial_ball_x    = 325,
    parameter int initial_ball_y    = 285,
    parameter int initial_dx        = 1,
    parameter int initial_dy        = 1,
    parameter int paddle_size_x     = 10,
    parameter int paddle_size_y     = 100,
    parameter int disp_shift        = 50,
    parameter int paddle_1_x        = 15,
    parameter int paddle_2_x        = 630,
    parameter int initial_paddle_dy = 3,
    parameter int initial_paddle_y  = 250,
    parameter int SERVE_TICKS       = 100,
    parameter int WIN_SCORE         = 11
) (
    input  logic       clk100Hz,
    input  logic       reset,
    input  logic       pause,
    input  logic [3:0] btn,
    output logic [3:0] score_1_ones,
    output logic [3:0] score_1_tens,
    output logic [3:0] score_2_ones,
    output logic [3:0] score_2_tens,
    output logic [9:0] paddle_1_y,
    output logic [9:0] paddle_2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] winner,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    // All geometry is evaluated in 11 bits so that sums near the bottom edge
    // cannot wrap.
    localparam logic [10:0] YMIN    = 11'(lower_lim_y + disp_shift);
    localparam logic [10:0] YMAX    = 11'(upper_lim_y + disp_shift);
    localparam logic [10:0] PMAX    = 11'(upper_lim_y + disp_shift - paddle_size_y);
    localparam logic [10:0] PH      = 11'(paddle_size_y);
    localparam logic [10:0] PSTEP   = 11'(initial_paddle_dy);
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] DX      = 11'(initial_dx);
    localparam logic [10:0] DY      = 11'(initial_dy);
    localparam logic [10:0] XMIN    = 11'(lower_lim_x);
    localparam logic [10:0] XMAX    = 11'(upper_lim_x);
    localparam logic [10:0] P1_FACE = 11'(paddle_1_x + paddle_size_x);
    localparam logic [10:0] P2_FACE = 11'(paddle_2_x);
    localparam logic [10:0] INIT_BX = 11'(initial_ball_x);
    localparam logic [10:0] INIT_BY = 11'(initial_ball_y);
    localparam logic [9:0]  INIT_PY = 10'(initial_paddle_y);
    localparam logic [7:0]  WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam int          CNT_W   = $clog2(SERVE_TICKS + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       ball_x_q, ball_y_q, pad_1_q, pad_2_q;
    logic [10:0]      ball_x_d, ball_y_d, pad_1_d, pad_2_d;
    logic             right_q, right_d, down_q, down_d;
    logic [7:0]       s1_q, s1_d, s2_q, s2_d;   // {tens, ones}
    logic [1:0]       winner_q, winner_d;

    logic [10:0] bx, by, p1, p2;
    logic        hit_1, hit_2, point_1, point_2;
    logic [7:0]  s_new;

    assign bx = {1'b0, ball_x_q};
    assign by = {1'b0, ball_y_q};
    assign p1 = {1'b0, pad_1_q};
    assign p2 = {1'b0, pad_2_q};

    function automatic logic [10:0] move_paddle(input logic [10:0] y, input logic up,
                                                 input logic dn);
        logic [10:0] r;
        r = y;
        if (up && !dn)      r = (y < YMIN + PSTEP) ? YMIN : y - PSTEP;
        else if (dn && !up) r = (y + PSTEP > PMAX) ? PMAX : y + PSTEP;
        return r;
    endfunction

    function automatic logic overlap(input logic [10:0] ball_top, input logic [10:0] pad_top);
        return (ball_top + BS > pad_top) && (ball_top < pad_top + PH);
    endfunction

    // BCD increment that saturates at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)        return s;
        if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ball_x_d = bx;
        ball_y_d = by;
        right_d  = right_q;
        down_d   = down_q;
        pad_1_d  = p1;
        pad_2_d  = p2;
        s1_d     = s1_q;
        s2_d     = s2_q;
        winner_d = winner_q;
        hit_1    = 1'b0;
        hit_2    = 1'b0;
        point_1  = 1'b0;
        point_2  = 1'b0;
        s_new    = 8'h00;
        if (!pause && state_q != ST_OVER) begin
            pad_1_d = move_paddle(p1, btn[3], btn[2]);
            pad_2_d = move_paddle(p2, btn[1], btn[0]);
            if (state_q == ST_SERVE) begin
                if (cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                // Vertical axis: independent of anything horizontal.
                if (down_q) begin
                    if (by + DY + BS >= YMAX) begin
                        ball_y_d = YMAX - BS;
                        down_d   = 1'b0;
                    end else begin
                        ball_y_d = by + DY;
                    end
                end else if (by <= YMIN + DY) begin
                    ball_y_d = YMIN;
                    down_d   = 1'b1;
                end else begin
                    ball_y_d = by - DY;
                end
                // Horizontal axis: a hit needs the leading face to reach the
                // paddle face on this step while the ball overlaps vertically.
                hit_1   = !right_q && (bx >= P1_FACE) && (bx <= P1_FACE + DX) && overlap(by, p1);
                hit_2   = right_q && (bx + BS <= P2_FACE) && (bx + DX + BS >= P2_FACE)
                          && overlap(by, p2);
                point_2 = !right_q && (bx <= XMIN + DX);
                point_1 = right_q && (bx + DX + BS >= XMAX);
                if (hit_1) begin
                    ball_x_d = P1_FACE;
                    right_d  = 1'b1;
                end else if (hit_2) begin
                    ball_x_d = P2_FACE - BS;
                    right_d  = 1'b0;
                end else if (point_1 || point_2) begin
                    s_new = point_1 ? bcd_inc(s1_q) : bcd_inc(s2_q);
                    if (point_1) s1_d = s_new;
                    else         s2_d = s_new;
                    if (s_new == WIN_BCD) begin
                        // Final point: the ball stays where the miss happened.
                        state_d  = ST_OVER;
                        winner_d = point_1 ? 2'b01 : 2'b10;
                        ball_x_d = bx;
                        ball_y_d = by;
                        down_d   = down_q;
                    end else begin
                        // Re-serve from centre, heading back toward the side
                        // that just won the point; y direction carries over.
                        state_d  = ST_SERVE;
                        cnt_d    = '0;
                        ball_x_d = INIT_BX;
                        ball_y_d = INIT_BY;
                        right_d  = point_2;
                    end
                end else begin
                    ball_x_d = right_q ? bx + DX : bx - DX;
                end
            end
        end
    end

    always_ff @(posedge clk100Hz or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SERVE;
            cnt_q    <= '0;
            ball_x_q <= INIT_BX[9:0];
            ball_y_q <= INIT_BY[9:0];
            right_q  <= 1'b1;
            down_q   <= 1'b1;
            pad_1_q  <= INIT_PY;
            pad_2_q  <= INIT_PY;
            s1_q     <= 8'h00;
            s2_q     <= 8'h00;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ball_x_q <= ball_x_d[9:0];
            ball_y_q <= ball_y_d[9:0];
            right_q  <= right_d;
            down_q   <= down_d;
            pad_1_q  <= pad_1_d[9:0];
            pad_2_q  <= pad_2_d[9:0];
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            winner_q <= winner_d;
        end
    end

    assign score_1_ones = s1_q[3:0];
    assign score_1_tens = s1_q[7:4];
    assign score_2_ones = s2_q[3:0];
    assign score_2_tens = s2_q[7:4];
    assign paddle_1_y   = pad_1_q;
    assign paddle_2_y   = pad_2_q;
    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign winner       = winner_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Testbench for pong_game_engine: directed phases with randomized buttons,
// checked every tick against an integer game model.
module tb_pong_game_engine;

    logic       clk100Hz = 1'b0;
    logic       reset;
    logic       pause;
    logic [3:0] btn;
    logic [3:0] score_1_ones, score_1_tens, score_2_ones, score_2_tens;
    logic [9:0] paddle_1_y, paddle_2_y, ball_x, ball_y;
    logic [1:0] winner, dbg_state;

    pong_game_engine dut (
        .clk100Hz    (clk100Hz),
        .reset       (reset),
        .pause       (pause),
        .btn         (btn),
        .score_1_ones(score_1_ones),
        .score_1_tens(score_1_tens),
        .score_2_ones(score_2_ones),
        .score_2_tens(score_2_tens),
        .paddle_1_y  (paddle_1_y),
        .paddle_2_y  (paddle_2_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .winner      (winner),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk100Hz = ~clk100Hz;

    int checks = 0;
    int errors = 0;

    // ---------------- game model ----------------
    // mode: 0 serving, 1 playing, 2 game over. Scores kept as plain integers.
    int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_winner, m_mode, m_served;
    bit m_right, m_down, m_hit2;

    task automatic model_reset();
        m_bx = 325; m_by = 285; m_p1 = 250; m_p2 = 250;
        m_s1 = 0; m_s2 = 0; m_winner = 0; m_mode = 0; m_served = 0;
        m_right = 1'b1; m_down = 1'b1;
    endtask

    function automatic int paddle_next(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 3 < 55) ? 55 : y - 3;
        if (dn && !up) return (y + 3 > 420) ? 420 : y + 3;
        return y;
    endfunction

    task automatic model_step(input logic [3:0] b, input logic p);
        int nx, ny, scorer;
        bit nr, nd, ov1, ov2;
        if (p || m_mode == 2) return;
        ov1 = (m_by + 5 > m_p1) && (m_by < m_p1 + 100);
        ov2 = (m_by + 5 > m_p2) && (m_by < m_p2 + 100);
        m_p1 = paddle_next(m_p1, b[3], b[2]);
        m_p2 = paddle_next(m_p2, b[1], b[0]);
        if (m_mode == 0) begin
            m_served++;
            if (m_served == 100) begin
                m_mode = 1;
                m_served = 0;
            end
            return;
        end
        nd = m_down; nr = m_right; nx = m_bx; scorer = 0;
        if (m_down) begin
            if (m_by + 6 >= 520) begin ny = 515; nd = 1'b0; end
            else ny = m_by + 1;
        end else begin
            if (m_by - 1 <= 55) begin ny = 55; nd = 1'b1; end
            else ny = m_by - 1;
        end
        if (!m_right && m_bx >= 25 && m_bx - 1 <= 25 && ov1) begin
            nx = 25; nr = 1'b1;
        end else if (m_right && m_bx + 5 <= 630 && m_bx + 6 >= 630 && ov2) begin
            nx = 625; nr = 1'b0; m_hit2 = 1'b1;
        end else if (!m_right && m_bx - 1 <= 10) begin
            scorer = 2;
        end else if (m_right && m_bx + 6 >= 640) begin
            scorer = 1;
        end else begin
            nx = m_right ? m_bx + 1 : m_bx - 1;
        end
        if (scorer != 0) begin
            if (scorer == 1) m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
            else             m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
            if ((scorer == 1 ? m_s1 : m_s2) == 11) begin
                m_mode = 2;
                m_winner = scorer;
                return;  // ball stays where the final miss happened
            end
            m_mode = 0; m_served = 0;
            nx = 325; ny = 285; nr = (scorer == 2);
        end
        m_bx = nx; m_by = ny; m_right = nr; m_down = nd;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " ball_x"}, 32'(ball_x), m_bx);
        chk({tag, " ball_y"}, 32'(ball_y), m_by);
        chk({tag, " paddle_1_y"}, 32'(paddle_1_y), m_p1);
        chk({tag, " paddle_2_y"}, 32'(paddle_2_y), m_p2);
        chk({tag, " score_1_tens"}, 32'(score_1_tens), m_s1 / 10);
        chk({tag, " score_1_ones"}, 32'(score_1_ones), m_s1 % 10);
        chk({tag, " score_2_tens"}, 32'(score_2_tens), m_s2 / 10);
        chk({tag, " score_2_ones"}, 32'(score_2_ones), m_s2 % 10);
        chk({tag, " winner"}, 32'(winner), m_winner);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives inputs, lets one rising edge happen,
    // steps the model, checks just after the edge, returns at the next fall.
    task automatic tick(input logic [3:0] b, input logic p);
        btn = b;
        pause = p;
        @(posedge clk100Hz);
        model_step(b, p);
        #1;
        check_all("tick");
        @(negedge clk100Hz);
    endtask

    // {up, down} to keep a paddle centred on the ball
    function automatic logic [1:0] track(input int py);
        if (m_by + 2 > py + 52) return 2'b01;
        if (m_by + 2 < py + 48) return 2'b10;
        return 2'b00;
    endfunction

    // {up, down} to run away from the ball
    function automatic logic [1:0] avoid(input int py);
        return (m_by + 2 < py + 50) ? 2'b01 : 2'b10;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit seen10;
        logic [9:0] sx, sy, sp1, sp2;
        logic [1:0] sw;

        reset = 1'b1; pause = 1'b0; btn = 4'b0000;
        model_reset();
        #2;
        check_all("reset");
        chk("reset dbg_state", 32'(dbg_state), 0);
        @(negedge clk100Hz);
        reset = 1'b0;

        // Serve period with paddles driven into both clamps.
        for (int t = 1; t <= 100; t++) begin
            tick((t <= 70) ? 4'b1001 : 4'b1111, 1'b0);
            if (t == 57)  chk("p2 clamp at tick 57", 32'(paddle_2_y), 420);
            if (t == 65)  chk("p1 clamp at tick 65", 32'(paddle_1_y), 55);
            if (t == 100) chk("ball held through serve", 32'(ball_x), 325);
        end
        tick(4'b0000, 1'b0);
        chk("first ball move", 32'(ball_x), 326);

        // Random buttons during play.
        for (int t = 0; t < 400; t++) tick(4'($urandom_range(0, 15)), 1'b0);

        // Pause in PLAY, then reset asynchronously while paused.
        n = 0;
        while (m_mode != 1 && n < 400) begin
            tick(4'($urandom_range(0, 15)), 1'b0);
            n++;
        end
        chk("reached play before pause", 32'(m_mode), 1);
        sx = ball_x; sy = ball_y; sp1 = paddle_1_y; sp2 = paddle_2_y;
        for (int t = 0; t < 50; t++) begin
            tick(4'($urandom_range(0, 15)), 1'b1);
            chk("pause hold ball_x", 32'(ball_x), 32'(sx));
            chk("pause hold ball_y", 32'(ball_y), 32'(sy));
            chk("pause hold paddle_1_y", 32'(paddle_1_y), 32'(sp1));
            chk("pause hold paddle_2_y", 32'(paddle_2_y), 32'(sp2));
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async reset");
        chk("async reset dbg_state", 32'(dbg_state), 0);
        @(negedge clk100Hz);
        reset = 1'b0;
        pause = 1'b0;

        // Both paddles track the ball until paddle 2 returns it.
        m_hit2 = 1'b0;
        n = 0;
        while (!m_hit2 && n < 3000) begin
            tick({track(m_p1), track(m_p2)}, 1'b0);
            n++;
        end
        chk("paddle 2 hit seen", 32'(m_hit2), 1);
        if (m_hit2) begin
            chk("p2 hit ball_x", 32'(ball_x), 625);
            tick(4'b0000, 1'b0);
            chk("after p2 hit ball_x", 32'(ball_x), 624);
        end

        // Player 1 returns everything, player 2 dodges, until the game ends.
        seen10 = 1'b0;
        n = 0;
        while (m_mode != 2 && n < 30000) begin
            tick({track(m_p1), avoid(m_p2)}, ($urandom_range(0, 31) == 0));
            if (m_s1 == 10 && !seen10) begin
                seen10 = 1'b1;
                chk("tenth point tens", 32'(score_1_tens), 1);
                chk("tenth point ones", 32'(score_1_ones), 0);
            end
            n++;
        end
        chk("game over winner", 32'(winner), 1);
        chk("game over dbg_state", 32'(dbg_state), 2);

        // Everything frozen after the win.
        sx = ball_x; sy = ball_y; sp1 = paddle_1_y; sp2 = paddle_2_y; sw = winner;
        for (int t = 0; t < 200; t++) begin
            tick(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            chk("frozen ball_x", 32'(ball_x), 32'(sx));
            chk("frozen ball_y", 32'(ball_y), 32'(sy));
            chk("frozen paddle_1_y", 32'(paddle_1_y), 32'(sp1));
            chk("frozen paddle_2_y", 32'(paddle_2_y), 32'(sp2));
            chk("frozen winner", 32'(winner), 32'(sw));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
